// File: rtl/time_field_pkg.sv
// Shared encodings for the clock-chip time-field counters: mode codes, FSM states and field moduli.
package time_field_pkg;

    localparam logic [1:0] MODE_RUN    = 2'b00;
    localparam logic [1:0] MODE_EDIT_A = 2'b01;
    localparam logic [1:0] MODE_EDIT_B = 2'b10;
    localparam logic [1:0] MODE_COMMIT = 2'b11;

    typedef enum logic [1:0] {
        S_RUN  = 2'b00,
        S_EDIT = 2'b01,
        S_HOLD = 2'b10
    } state_t;

    localparam int unsigned SEC_MOD  = 60;
    localparam int unsigned MIN_MOD  = 60;
    localparam int unsigned HOUR_MOD = 24;

    function automatic logic is_edit_mode(input logic [1:0] m);
        return (m == MODE_EDIT_A) || (m == MODE_EDIT_B);
    endfunction

endpackage

// File: rtl/tick_edge_sync.sv
// Synchronises an asynchronous level and emits a one-cycle pulse on each rising edge.
// Pulse appears SYNC_STAGES clocks after the input edge is first sampled.
module tick_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], level};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/time_field_counter.sv
// Modulo-MODULUS time-field counter with edit/stage/commit; chain carry_out into the next tick_in.
// Define TIME_FIELD_DOWN_EN to add the dir port (1 = count down with borrow pulse).
module time_field_counter
    import time_field_pkg::*;
#(
    parameter int unsigned WIDTH       = 6,
    parameter int unsigned MODULUS     = 24,
    parameter int unsigned INIT        = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic [1:0]       mode,
    input  logic             field_en,
    input  logic [WIDTH-1:0] set_val,
`ifdef TIME_FIELD_DOWN_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] count,
    output logic             carry_out,
    output logic             staged,
    output logic             set_err
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] stage_q, stage_d;
    logic             staged_q, staged_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;
    logic             tick_ev;
    logic             down;
    logic             set_ok;

    tick_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_tick_sync (
        .clk   (clk),
        .rst   (rst),
        .level (tick_in),
        .pulse (tick_ev)
    );

`ifdef TIME_FIELD_DOWN_EN
    assign down = dir;
`else
    assign down = 1'b0;
`endif

    assign set_ok = (32'(set_val) < MODULUS);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        stage_d  = stage_q;
        staged_d = staged_q;
        carry_d  = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_RUN: begin
                // Ticks only advance the field while running; wrap and borrow both pulse carry.
                if (tick_ev) begin
                    if (down) begin
                        if (count_q == '0) begin
                            count_d = MAX_VAL;
                            carry_d = 1'b1;
                        end else begin
                            count_d = count_q - ONE;
                        end
                    end else begin
                        if (count_q == MAX_VAL) begin
                            count_d = '0;
                            carry_d = 1'b1;
                        end else begin
                            count_d = count_q + ONE;
                        end
                    end
                end
                if (is_edit_mode(mode)) begin
                    state_d = S_EDIT;
                end else if (mode == MODE_COMMIT) begin
                    state_d  = S_HOLD;
                    staged_d = 1'b0;
                end
            end

            S_EDIT: begin
                if (field_en && is_edit_mode(mode)) begin
                    if (set_ok) begin
                        stage_d  = set_val;
                        staged_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (mode == MODE_RUN) begin
                    state_d  = S_RUN;
                    staged_d = 1'b0;
                end else if (mode == MODE_COMMIT) begin
                    state_d = S_HOLD;
                    // Load happens only on this transition, so holding COMMIT cannot re-load.
                    if (field_en && staged_q) begin
                        count_d  = stage_q;
                        staged_d = 1'b0;
                    end
                end
            end

            S_HOLD: begin
                if (mode == MODE_RUN) begin
                    state_d  = S_RUN;
                    staged_d = 1'b0;
                end else if (is_edit_mode(mode)) begin
                    state_d = S_EDIT;
                end
            end

            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_RUN;
            count_q  <= INIT_VAL;
            stage_q  <= '0;
            staged_q <= 1'b0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            stage_q  <= stage_d;
            staged_q <= staged_d;
            carry_q  <= carry_d;
            err_q    <= err_d;
        end
    end

    assign count     = count_q;
    assign carry_out = carry_q;
    assign staged    = staged_q;
    assign set_err   = err_q;

endmodule

// File: tb/tb_time_field_counter.sv
// Self-checking bench for time_field_counter: directed scenarios plus random stimulus
// compared every cycle against a modular-arithmetic reference model.
module tb_time_field_counter;
    import time_field_pkg::*;

    localparam int unsigned WIDTH       = 6;
    localparam int unsigned MODULUS     = HOUR_MOD;
    localparam int unsigned INIT        = 5;
    localparam int unsigned SYNC_STAGES = 2;

    localparam int PH_RUN  = 0;
    localparam int PH_EDIT = 1;
    localparam int PH_HOLD = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             tick_in;
    logic [1:0]       mode;
    logic             field_en;
    logic [WIDTH-1:0] set_val;
`ifdef TIME_FIELD_DOWN_EN
    logic             dir;
`endif
    logic [WIDTH-1:0] count;
    logic             carry_out;
    logic             staged;
    logic             set_err;

    int n_cmp = 0;
    int n_err = 0;

    int m_count, m_stage, m_staged, m_carry, m_err, m_phase;
    bit hist[$];

    always #5 clk = ~clk;

    time_field_counter #(
        .WIDTH       (WIDTH),
        .MODULUS     (MODULUS),
        .INIT        (INIT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_in   (tick_in),
        .mode      (mode),
        .field_en  (field_en),
        .set_val   (set_val),
`ifdef TIME_FIELD_DOWN_EN
        .dir       (dir),
`endif
        .count     (count),
        .carry_out (carry_out),
        .staged    (staged),
        .set_err   (set_err)
    );

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic bit cur_dir();
`ifdef TIME_FIELD_DOWN_EN
        return dir;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_count  = INIT;
        m_stage  = 0;
        m_staged = 0;
        m_carry  = 0;
        m_err    = 0;
        m_phase  = PH_RUN;
        hist.delete();
        for (int i = 0; i < SYNC_STAGES + 1; i++) hist.push_back(1'b0);
    endtask

    // One clock of reference behaviour, using the inputs held across the edge.
    task automatic model_step();
        bit ev;
        bit edit_m;
        hist.push_back(tick_in);
        ev = hist[1] && !hist[0];
        void'(hist.pop_front());
        edit_m = (mode == MODE_EDIT_A) || (mode == MODE_EDIT_B);
        m_carry = 0;
        m_err   = 0;
        if (m_phase == PH_RUN) begin
            if (ev) begin
                if (cur_dir()) begin
                    m_carry = (m_count == 0);
                    m_count = (m_count + MODULUS - 1) % MODULUS;
                end else begin
                    m_count = (m_count + 1) % MODULUS;
                    m_carry = (m_count == 0);
                end
            end
            if (edit_m) m_phase = PH_EDIT;
            else if (mode == MODE_COMMIT) m_phase = PH_HOLD;
        end else if (m_phase == PH_EDIT) begin
            if (field_en && edit_m) begin
                if (set_val < MODULUS) begin
                    m_stage  = set_val;
                    m_staged = 1;
                end else begin
                    m_err = 1;
                end
            end
            if (mode == MODE_RUN) begin
                m_phase = PH_RUN;
            end else if (mode == MODE_COMMIT) begin
                m_phase = PH_HOLD;
                if (field_en && m_staged == 1) begin
                    m_count  = m_stage;
                    m_staged = 0;
                end
            end
        end else begin
            if (mode == MODE_RUN) m_phase = PH_RUN;
            else if (edit_m) m_phase = PH_EDIT;
        end
        // A staged value never survives into run mode.
        if (m_phase == PH_RUN) m_staged = 0;
    endtask

    task automatic compare_all();
        check_val("count", count, m_count);
        check_val("carry_out", carry_out, m_carry);
        check_val("staged", staged, m_staged);
        check_val("set_err", set_err, m_err);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        compare_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load_value(input int v);
        mode     = MODE_EDIT_A;
        field_en = 1'b1;
        set_val  = WIDTH'(v);
        cycles(3);
        mode = MODE_COMMIT;
        cycle();
        mode = MODE_RUN;
        cycle();
    endtask

    initial begin
        int carries;
        rst      = 1'b1;
        tick_in  = 1'b0;
        mode     = MODE_RUN;
        field_en = 1'b0;
        set_val  = '0;
`ifdef TIME_FIELD_DOWN_EN
        dir      = 1'b0;
`endif
        model_reset();
        cycles(2);
        check_val("reset_count", count, INIT);
        check_val("reset_staged", staged, 0);
        rst = 1'b0;
        cycles(2);

        // Wrap from 22 through 23 to 0 with a single carry pulse.
        load_value(22);
        check_val("load22", count, 22);
        tick_in = 1'b1;
        cycles(4);
        tick_in = 1'b0;
        cycles(3);
        check_val("first_tick", count, 23);
        tick_in = 1'b1;
        carries = 0;
        cycles(SYNC_STAGES);
        carries += carry_out;
        cycle();
        check_val("wrap_count", count, 0);
        check_val("wrap_carry", carry_out, 1);
        carries += carry_out;
        cycles(3);
        carries += carry_out;
        check_val("carry_pulses", carries, 1);

        // Level held high: exactly one increment, SYNC_STAGES+1 clocks after the edge.
        tick_in = 1'b0;
        cycles(4);
        tick_in = 1'b1;
        cycles(SYNC_STAGES);
        check_val("latency_before", count, 0);
        cycle();
        check_val("latency_at", count, 1);
        cycles(49);
        check_val("held_high", count, 1);
        tick_in = 1'b0;
        cycles(3);

        // Commit 15, then hold COMMIT with a new set_val: no re-load.
        mode     = MODE_EDIT_B;
        field_en = 1'b1;
        set_val  = 6'd15;
        cycles(2);
        check_val("staged_set", staged, 1);
        mode = MODE_COMMIT;
        cycle();
        check_val("commit15", count, 15);
        check_val("commit_staged", staged, 0);
        set_val = 6'd3;
        cycles(10);
        check_val("hold_noreload", count, 15);
        mode = MODE_RUN;
        cycle();

        // Out-of-range value rejected.
        mode    = MODE_EDIT_A;
        set_val = 6'd24;
        cycles(2);
        check_val("err_pulse", set_err, 1);
        check_val("err_staged", staged, 0);
        field_en = 1'b0;
        cycle();
        check_val("err_clear", set_err, 0);
        field_en = 1'b1;
        mode     = MODE_COMMIT;
        cycles(2);
        check_val("err_nocommit", count, 15);
        mode = MODE_RUN;
        cycle();

        // Abandoned edit is discarded; ticks continue from the old value.
        mode    = MODE_EDIT_A;
        set_val = 6'd7;
        cycles(2);
        check_val("abandon_staged1", staged, 1);
        mode = MODE_RUN;
        cycle();
        check_val("abandon_staged0", staged, 0);
        check_val("abandon_count", count, 15);
        tick_in = 1'b1;
        cycles(SYNC_STAGES + 2);
        tick_in = 1'b0;
        check_val("abandon_tick", count, 16);
        cycles(3);

        // Asynchronous reset in the middle of an edit.
        mode    = MODE_EDIT_B;
        set_val = 6'd9;
        cycles(2);
        check_val("pre_rst_staged", staged, 1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_val("async_rst_count", count, INIT);
        check_val("async_rst_staged", staged, 0);
        mode = MODE_RUN;
        cycle();
        rst = 1'b0;
        cycles(2);

`ifdef TIME_FIELD_DOWN_EN
        // Borrow from 0 down to MODULUS-1.
        load_value(0);
        dir     = 1'b1;
        tick_in = 1'b1;
        cycles(SYNC_STAGES + 1);
        check_val("borrow_count", count, MODULUS - 1);
        check_val("borrow_carry", carry_out, 1);
        tick_in = 1'b0;
        cycles(3);
        dir = 1'b0;
`endif

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) tick_in = ~tick_in;
            if ($urandom_range(0, 11) == 0) mode = 2'($urandom_range(0, 3));
            field_en = ($urandom_range(0, 3) != 0);
            set_val  = WIDTH'($urandom_range(0, 30));
`ifdef TIME_FIELD_DOWN_EN
            if ($urandom_range(0, 15) == 0) dir = ~dir;
`endif
            rst = ($urandom_range(0, 499) == 0);
            cycle();
        end
        rst = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
